fm_demod_iq: RTL and testbench

Parametrised quadrature FM demodulator, successor to the fixed 16-bit mode-gated demodulator.
- Mixes the offset-binary FM input with external NCO sine/cosine and decimates I/Q with a built-in integrate-and-dump stage.
- Applies the cross-product discriminator I[n-1]·Q[n] − I[n]·Q[n-1].
- Outputs either frequency (discriminator) or its running integral, with a settle period, valid strobe, sync clear and saturation.
- Sits between the SINCOS NCO and the DAC path.

---
 rtl/fm_demod_iq.sv | 149 ++++++++++++++
 tb/tb_fm_demod_iq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fm_demod_iq.sv
// Quadrature FM demodulator: NCO mixing, integrate-and-dump decimation and
// cross-product discriminator, with an optional running-integral output.
module fm_demod_iq #(
    parameter int DW             = 16,
    parameter int DEC            = 4,
    parameter int OW             = 16,
    parameter int OSHIFT         = 16,
    parameter int SETTLE         = 2,
    parameter int OUT_OFFSET_BIN = 1
) (
    input  logic          clk_100M,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          int_mode,
    input  logic [DW-1:0] sig_in,
    input  logic [DW-1:0] sin_in,
    input  logic [DW-1:0] cos_in,
    output logic [OW-1:0] dem_out,
    output logic          dem_valid,
    output logic          settled
);

    localparam int LD   = $clog2(DEC);
    localparam int PW   = 2 * DW;
    localparam int ACCW = PW + LD;
    localparam int DWD  = PW + 1;
    localparam int IW   = PW + 8;
    localparam int SCW  = $clog2(SETTLE + 1);

    localparam logic [OW-1:0]  RST_OUT  = (OUT_OFFSET_BIN != 0) ? {1'b1, {(OW-1){1'b0}}} : {OW{1'b0}};
    localparam logic [LD-1:0]  CNT_LAST = LD'(DEC - 1);
    localparam logic [SCW-1:0] SETTLE_V = SCW'(SETTLE);

    function automatic logic [OW-1:0] fmt(input logic [OW-1:0] v);
        if (OUT_OFFSET_BIN != 0) begin
            fmt = {~v[OW-1], v[OW-2:0]};
        end else begin
            fmt = v;
        end
    endfunction

    function automatic logic [OW-1:0] sat_d(input logic signed [DWD-1:0] v);
        logic signed [DWD-1:0] maxv;
        logic signed [DWD-1:0] minv;
        maxv = {{(DWD-OW+1){1'b0}}, {(OW-1){1'b1}}};
        minv = {{(DWD-OW+1){1'b1}}, {(OW-1){1'b0}}};
        if (v > maxv) begin
            sat_d = maxv[OW-1:0];
        end else if (v < minv) begin
            sat_d = minv[OW-1:0];
        end else begin
            sat_d = v[OW-1:0];
        end
    endfunction

    logic signed [DW-1:0]   xs, ss, cs;
    logic                   v0, v1;
    logic signed [PW-1:0]   pi, pq;
    logic signed [ACCW-1:0] acc_i, acc_q;
    logic [LD-1:0]          cnt;
    logic signed [DW-1:0]   i_dec, q_dec, i_prev, q_prev;
    logic                   dec_valid, p_valid;
    logic signed [PW-1:0]   p1, p2;
    logic signed [IW-1:0]   int_r;
    logic [SCW-1:0]         settle_cnt;

    logic signed [ACCW-1:0] acc_sum_i, acc_sum_q;
    logic signed [DWD-1:0]  d_s;
    logic signed [IW-1:0]   int_nx;

    // Dump sums, discriminator difference and next integrator value
    always_comb begin
        acc_sum_i = acc_i + {{LD{pi[PW-1]}}, pi};
        acc_sum_q = acc_q + {{LD{pq[PW-1]}}, pq};
        d_s       = {p1[PW-1], p1} - {p2[PW-1], p2};
        int_nx    = int_r + {{(IW-DWD){d_s[DWD-1]}}, d_s};
    end

    // Whole pipeline; v0/v1 keep the block counter aligned to real samples after reset/clr
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            xs <= '0; ss <= '0; cs <= '0; v0 <= 1'b0; v1 <= 1'b0;
            pi <= '0; pq <= '0; acc_i <= '0; acc_q <= '0; cnt <= '0;
            i_dec <= '0; q_dec <= '0; dec_valid <= 1'b0;
            i_prev <= '0; q_prev <= '0; p1 <= '0; p2 <= '0; p_valid <= 1'b0;
            int_r <= '0; settle_cnt <= '0;
            dem_out <= RST_OUT; dem_valid <= 1'b0; settled <= 1'b0;
        end else if (clr) begin
            xs <= '0; ss <= '0; cs <= '0; v0 <= 1'b0; v1 <= 1'b0;
            pi <= '0; pq <= '0; acc_i <= '0; acc_q <= '0; cnt <= '0;
            i_dec <= '0; q_dec <= '0; dec_valid <= 1'b0;
            i_prev <= '0; q_prev <= '0; p1 <= '0; p2 <= '0; p_valid <= 1'b0;
            int_r <= '0; settle_cnt <= '0;
            dem_out <= RST_OUT; dem_valid <= 1'b0; settled <= 1'b0;
        end else if (en) begin
            xs <= {~sig_in[DW-1], sig_in[DW-2:0]};
            ss <= {~sin_in[DW-1], sin_in[DW-2:0]};
            cs <= {~cos_in[DW-1], cos_in[DW-2:0]};
            v0 <= 1'b1;
            pi <= xs * ss;
            pq <= xs * cs;
            v1 <= v0;

            dec_valid <= v1 && (cnt == CNT_LAST);
            if (v1) begin
                cnt <= cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    i_dec <= acc_sum_i[ACCW-1 -: DW];
                    q_dec <= acc_sum_q[ACCW-1 -: DW];
                    acc_i <= '0;
                    acc_q <= '0;
                end else begin
                    acc_i <= acc_sum_i;
                    acc_q <= acc_sum_q;
                end
            end

            p_valid <= dec_valid;
            if (dec_valid) begin
                p1     <= i_prev * q_dec;
                p2     <= i_dec * q_prev;
                i_prev <= i_dec;
                q_prev <= q_dec;
            end

            if (p_valid) begin
                int_r <= int_nx;
                if (settle_cnt < SETTLE_V) begin
                    settle_cnt <= settle_cnt + 1'b1;
                    dem_valid  <= 1'b0;
                end else begin
                    dem_valid <= 1'b1;
                    settled   <= 1'b1;
                    if (int_mode) begin
                        dem_out <= fmt(OW'(int_nx >>> OSHIFT));
                    end else begin
                        dem_out <= fmt(sat_d(d_s >>> OSHIFT));
                    end
                end
            end else begin
                dem_valid <= 1'b0;
            end
        end else begin
            dem_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fm_demod_iq.sv
// Directed bench for fm_demod_iq: one DUT with OSHIFT=16 and one with OSHIFT=8
// share all inputs; outputs are logged per cycle and looked up by cycle number.
module tb_fm_demod_iq;

    logic        clk = 1'b0;
    logic        rst, en, clr, int_mode;
    logic [15:0] sig_in, sin_in, cos_in;
    logic [15:0] dem_out, dem_out8;
    logic        dem_valid, dem_valid8, settled, settled8;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_c   = 0;

    logic [15:0] vq[$];
    logic [15:0] vq8[$];
    int          cq[$];
    int          cq8[$];

    localparam logic [15:0] ONE_Q = 16'hC000;
    localparam logic [15:0] ZERO  = 16'h8000;
    localparam logic [15:0] NEG_Q = 16'h4000;

    fm_demod_iq #(.DW(16), .DEC(4), .OW(16), .OSHIFT(16), .SETTLE(2), .OUT_OFFSET_BIN(1)) u_dut (
        .clk_100M(clk), .rst(rst), .en(en), .clr(clr), .int_mode(int_mode),
        .sig_in(sig_in), .sin_in(sin_in), .cos_in(cos_in),
        .dem_out(dem_out), .dem_valid(dem_valid), .settled(settled)
    );

    fm_demod_iq #(.DW(16), .DEC(4), .OW(16), .OSHIFT(8), .SETTLE(2), .OUT_OFFSET_BIN(1)) u_sat (
        .clk_100M(clk), .rst(rst), .en(en), .clr(clr), .int_mode(int_mode),
        .sig_in(sig_in), .sin_in(sin_in), .cos_in(cos_in),
        .dem_out(dem_out8), .dem_valid(dem_valid8), .settled(settled8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dem_valid) begin
            vq.push_back(dem_out);
            cq.push_back(cyc);
        end
        if (dem_valid8) begin
            vq8.push_back(dem_out8);
            cq8.push_back(cyc);
        end
    end

    // {found, value} of the output logged in cycle c
    function automatic logic [16:0] out_at(input int c, input bit sat);
        if (sat) begin
            foreach (cq8[i]) if (cq8[i] == c) return {1'b1, vq8[i]};
        end else begin
            foreach (cq[i]) if (cq[i] == c) return {1'b1, vq[i]};
        end
        return 17'h0_0000;
    endfunction

    task automatic clear_log;
        vq.delete(); vq8.delete(); cq.delete(); cq8.delete();
    endtask

    task automatic feed(input logic [15:0] si, input logic [15:0] co, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en = 1'b1; clr = 1'b0;
            sig_in = ONE_Q; sin_in = si; cos_in = co;
            last_c = cyc;
        end
    endtask

    task automatic test_reset;
        logic [16:0] r;
        int c1, c2, c3;
        @(negedge clk);
        checks++; if (dem_out !== 16'h8000) begin failures++; $display("FAIL reset_out got=%h exp=8000", dem_out); end
        checks++; if (dem_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dem_valid); end
        checks++; if (settled !== 1'b0) begin failures++; $display("FAIL reset_settled got=%b exp=0", settled); end
        rst = 1'b0;
        feed(ONE_Q, ZERO, 18);
        checks++; if (settled !== 1'b1) begin failures++; $display("FAIL pre_reset_settled got=%b exp=1", settled); end
        #2; rst = 1'b1; en = 1'b0;
        #1;
        checks++; if (dem_out !== 16'h8000) begin failures++; $display("FAIL midreset_out got=%h exp=8000", dem_out); end
        checks++; if (dem_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", dem_valid); end
        checks++; if (settled !== 1'b0) begin failures++; $display("FAIL midreset_settled got=%b exp=0", settled); end
        @(negedge clk);
        clear_log();
        rst = 1'b0;
        feed(ONE_Q, ZERO, 4); c1 = last_c;
        feed(ONE_Q, ZERO, 4); c2 = last_c;
        feed(ONE_Q, ZERO, 4); c3 = last_c;
        feed(ONE_Q, ZERO, 8);
        r = out_at(c1 + 5, 1'b0);
        checks++; if (r !== 17'h0_0000) begin failures++; $display("FAIL settle_supp1 got=%h exp=00000", r); end
        r = out_at(c2 + 5, 1'b0);
        checks++; if (r !== 17'h0_0000) begin failures++; $display("FAIL settle_supp2 got=%h exp=00000", r); end
        r = out_at(c3 + 5, 1'b0);
        checks++; if (r !== 17'h1_8000) begin failures++; $display("FAIL settle_first got=%h exp=18000", r); end
        checks++; if (settled !== 1'b1) begin failures++; $display("FAIL settled_rise got=%b exp=1", settled); end
    endtask

    task automatic test_dc;
        clear_log();
        feed(ONE_Q, ZERO, 16);
        checks++; if (vq.size() < 3) begin failures++; $display("FAIL dc_count got=%0d exp>=3", vq.size()); end
        for (int i = 0; i < vq.size(); i++) begin
            checks++; if (vq[i] !== 16'h8000) begin failures++; $display("FAIL dc_out got=%h exp=8000", vq[i]); end
            if (i > 0) begin
                checks++; if (cq[i] - cq[i-1] != 4) begin failures++; $display("FAIL dc_spacing got=%0d exp=4", cq[i] - cq[i-1]); end
            end
        end
    endtask

    task automatic test_quarter;
        logic [16:0] r;
        int cb;
        clear_log();
        feed(ONE_Q, ZERO, 4);
        feed(ZERO, ONE_Q, 4); cb = last_c;
        feed(ONE_Q, ZERO, 12);
        r = out_at(cb + 5, 1'b0);
        checks++; if (r !== 17'h1_8100) begin failures++; $display("FAIL quarter_out got=%h exp=18100", r); end
        r = out_at(cb + 5, 1'b1);
        checks++; if (r !== 17'h1_FFFF) begin failures++; $display("FAIL sat_pos got=%h exp=1ffff", r); end
        r = out_at(cb + 9, 1'b0);
        checks++; if (r !== 17'h1_7F00) begin failures++; $display("FAIL quarter_rev got=%h exp=17f00", r); end
        r = out_at(cb + 9, 1'b1);
        checks++; if (r !== 17'h1_0000) begin failures++; $display("FAIL sat_neg got=%h exp=10000", r); end
    endtask

    task automatic test_integrate;
        logic [16:0] r;
        int c3, cb, cc, cd;
        @(negedge clk);
        clr = 1'b1; en = 1'b1; int_mode = 1'b1;
        @(negedge clk);
        clr = 1'b0; en = 1'b0;
        clear_log();
        feed(ONE_Q, ZERO, 12); c3 = last_c;
        feed(ZERO, ONE_Q, 4);  cb = last_c;
        feed(NEG_Q, ZERO, 4);  cc = last_c;
        feed(ZERO, NEG_Q, 4);  cd = last_c;
        feed(ZERO, NEG_Q, 1);
        int_mode = 1'b0;
        feed(ZERO, NEG_Q, 7);
        r = out_at(c3 + 5, 1'b0);
        checks++; if (r !== 17'h1_8000) begin failures++; $display("FAIL int_zero got=%h exp=18000", r); end
        r = out_at(cb + 5, 1'b0);
        checks++; if (r !== 17'h1_8100) begin failures++; $display("FAIL int_first got=%h exp=18100", r); end
        r = out_at(cc + 5, 1'b0);
        checks++; if (r !== 17'h1_8200) begin failures++; $display("FAIL int_second got=%h exp=18200", r); end
        r = out_at(cd + 5, 1'b0);
        checks++; if (r !== 17'h1_8100) begin failures++; $display("FAIL int_to_disc got=%h exp=18100", r); end
    endtask

    task automatic test_enable;
        logic [16:0] r;
        int cref;
        cref = last_c;
        clear_log();
        feed(ONE_Q, ZERO, 4);
        feed(ZERO, ONE_Q, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            en = 1'b0;
            sig_in = 16'($urandom); sin_in = 16'($urandom); cos_in = 16'($urandom);
        end
        feed(ZERO, ONE_Q, 2);
        feed(ONE_Q, ZERO, 4);
        feed(NEG_Q, ZERO, 4);
        feed(ZERO, NEG_Q, 8);
        r = out_at(cref + 9, 1'b0);
        checks++; if (r !== 17'h0_0000) begin failures++; $display("FAIL en_frozen got=%h exp=00000", r); end
        r = out_at(cref + 19, 1'b0);
        checks++; if (r !== 17'h1_8100) begin failures++; $display("FAIL en_blk1 got=%h exp=18100", r); end
        r = out_at(cref + 23, 1'b0);
        checks++; if (r !== 17'h1_8100) begin failures++; $display("FAIL en_blk2 got=%h exp=18100", r); end
        r = out_at(cref + 27, 1'b0);
        checks++; if (r !== 17'h1_7F00) begin failures++; $display("FAIL en_blk3 got=%h exp=17f00", r); end
        r = out_at(cref + 31, 1'b0);
        checks++; if (r !== 17'h1_8000) begin failures++; $display("FAIL en_blk4 got=%h exp=18000", r); end
    endtask

    task automatic test_clear;
        logic [16:0] r;
        int c1, c2, c3;
        checks++; if (settled !== 1'b1) begin failures++; $display("FAIL pre_clr_settled got=%b exp=1", settled); end
        @(negedge clk);
        clr = 1'b1; en = 1'b1; int_mode = 1'b1;
        @(negedge clk);
        clr = 1'b0; en = 1'b0;
        clear_log();
        checks++; if (dem_out !== 16'h8000) begin failures++; $display("FAIL clr_out got=%h exp=8000", dem_out); end
        checks++; if (settled !== 1'b0) begin failures++; $display("FAIL clr_settled got=%b exp=0", settled); end
        checks++; if (dem_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", dem_valid); end
        feed(ONE_Q, ZERO, 4); c1 = last_c;
        feed(ONE_Q, ZERO, 4); c2 = last_c;
        feed(ONE_Q, ZERO, 4); c3 = last_c;
        feed(ONE_Q, ZERO, 8);
        r = out_at(c1 + 5, 1'b0);
        checks++; if (r !== 17'h0_0000) begin failures++; $display("FAIL clr_supp1 got=%h exp=00000", r); end
        r = out_at(c2 + 5, 1'b0);
        checks++; if (r !== 17'h0_0000) begin failures++; $display("FAIL clr_supp2 got=%h exp=00000", r); end
        r = out_at(c3 + 5, 1'b0);
        checks++; if (r !== 17'h1_8000) begin failures++; $display("FAIL clr_int_restart got=%h exp=18000", r); end
        checks++; if (settled !== 1'b1) begin failures++; $display("FAIL clr_resettle got=%b exp=1", settled); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; int_mode = 1'b0;
        sig_in = ZERO; sin_in = ZERO; cos_in = ZERO;
        test_reset();
        test_dc();
        test_quarter();
        test_integrate();
        test_enable();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
